// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 set-2 keyboard event queue.
// Holds the parser state encoding, the special scan bytes and the event word layout.
package kbd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXT  = 2'd1,
        ST_BRK  = 2'd2
    } kbd_state_t;

    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;
    localparam logic [7:0] BYTE_E1 = 8'hE1;
    localparam logic [7:0] BYTE_AA = 8'hAA;
    localparam logic [7:0] BYTE_FA = 8'hFA;
    localparam logic [7:0] BYTE_00 = 8'h00;
    localparam logic [7:0] BYTE_FF = 8'hFF;

    localparam int EVT_W          = 11;
    localparam int EVT_REPEAT_BIT = 10;
    localparam int EVT_BREAK_BIT  = 9;
    localparam int EVT_EXT_BIT    = 8;
    localparam int EVT_CODE_MSB   = 7;

    typedef struct packed {
        logic       is_repeat;
        logic       is_break;
        logic       extend;
        logic [7:0] code;
    } kbd_evt_t;

    function automatic kbd_evt_t pack_evt(input logic rpt, input logic brk, input logic [8:0] key);
        kbd_evt_t e;
        e.is_repeat = rpt;
        e.is_break  = brk;
        e.extend    = key[EVT_EXT_BIT];
        e.code      = key[EVT_CODE_MSB:0];
        return e;
    endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// Synchronous show-ahead FIFO; the head word is visible whenever the FIFO is non-empty
// and reads as zero when empty. A push while full is accepted only if a pop happens too.
module kbd_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 11
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_push,
    input  logic [WIDTH-1:0]               i_data,
    input  logic                           i_pop,
    output logic [WIDTH-1:0]               o_data,
    output logic                           o_full,
    output logic                           o_empty,
    output logic [$clog2(DEPTH+1)-1:0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = i_pop && !w_empty;
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/keyboard_event_queue.sv
// PS/2 set-2 scan-byte parser with key-down bitmap, auto-repeat for the last pressed key,
// and an event FIFO carrying every make, break and repeat to the consumer.
module keyboard_event_queue
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int REPEAT_EN    = 1,
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_RATE  = 10_000_000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              byte_valid,
    input  logic [7:0]                        byte_data,
    output logic [511:0]                      key_down,
    output logic                              evt_valid,
    input  logic                              evt_ready,
    output logic [10:0]                       evt_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              overflow
);
    kbd_state_t    r_state;
    kbd_state_t    w_state_nxt;
    logic          r_brk_ext;
    logic          w_brk_ext_nxt;
    logic          w_make;
    logic          w_break;
    logic          w_clear;
    logic          w_ext;

    logic [511:0]  r_key_down;
    logic          r_rep_active;
    logic [8:0]    r_rep_key;
    logic [31:0]   r_rep_cnt;
    logic          r_overflow;

    logic [8:0]    w_key;
    logic          w_held;
    logic          w_make_evt;
    logic          w_break_evt;
    logic          w_parse_push;
    logic          w_rep_due;
    logic          w_rep_push;
    logic          w_push;
    kbd_evt_t      w_push_evt;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic          w_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_brk_ext <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_brk_ext <= w_brk_ext_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_brk_ext_nxt = r_brk_ext;
        w_make        = 1'b0;
        w_break       = 1'b0;
        w_clear       = 1'b0;
        w_ext         = 1'b0;
        if (byte_valid) begin
            case (r_state)
                ST_IDLE: begin
                    case (byte_data)
                        BYTE_E0: w_state_nxt = ST_EXT;
                        BYTE_F0: begin
                            w_state_nxt   = ST_BRK;
                            w_brk_ext_nxt = 1'b0;
                        end
                        BYTE_E1, BYTE_FA, BYTE_00, BYTE_FF: ;
                        BYTE_AA: w_clear = 1'b1;
                        default: w_make = 1'b1;
                    endcase
                end
                ST_EXT: begin
                    if (byte_data == BYTE_F0) begin
                        w_state_nxt   = ST_BRK;
                        w_brk_ext_nxt = 1'b1;
                    end else if (byte_data != BYTE_E0) begin
                        w_make      = 1'b1;
                        w_ext       = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    w_break     = 1'b1;
                    w_ext       = r_brk_ext;
                    w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_key        = {w_ext, byte_data};
    assign w_held       = r_key_down[w_key];
    assign w_make_evt   = w_make && !w_held;
    assign w_break_evt  = w_break && w_held;
    assign w_parse_push = w_make_evt || w_break_evt;

    // A due repeat yields to a parser event and waits with the counter parked at zero.
    assign w_rep_due  = r_rep_active && (r_rep_cnt == '0);
    assign w_rep_push = w_rep_due && !w_parse_push;
    assign w_push     = w_parse_push || w_rep_push;
    assign w_push_evt = w_parse_push ? pack_evt(1'b0, w_break_evt, w_key)
                                     : pack_evt(1'b1, 1'b0, r_rep_key);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_down   <= '0;
            r_rep_active <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            // Counters are reloaded one below the target so the push lands exactly on it.
            if (w_rep_push)
                r_rep_cnt <= 32'(REPEAT_RATE - 1);
            else if (r_rep_active && r_rep_cnt != '0)
                r_rep_cnt <= r_rep_cnt - 32'd1;

            if (w_clear) begin
                r_key_down   <= '0;
                r_rep_active <= 1'b0;
            end else if (w_make_evt) begin
                r_key_down[w_key] <= 1'b1;
                r_rep_active      <= (REPEAT_EN != 0);
                r_rep_key         <= w_key;
                r_rep_cnt         <= 32'(REPEAT_DELAY - 1);
            end else if (w_break_evt) begin
                r_key_down[w_key] <= 1'b0;
                if (r_rep_key == w_key) r_rep_active <= 1'b0;
            end

            if (w_drop) r_overflow <= 1'b1;
        end
    end

    assign w_drop = w_push && w_fifo_full && !(evt_ready && !w_fifo_empty);

    kbd_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_evt),
        .i_pop   (evt_ready),
        .o_data  (evt_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (fifo_count)
    );

    assign key_down  = r_key_down;
    assign evt_valid = !w_fifo_empty;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_keyboard_event_queue.sv
// Self-checking bench for keyboard_event_queue: a byte table with bitmap checks,
// an event scoreboard fed at stimulus time, and hand-written repeat/FIFO/reset sequences.
module tb_keyboard_event_queue;
    localparam int DEPTH = 4;
    localparam int DLY   = 20;
    localparam int RATE  = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         byte_valid = 1'b0;
    logic [7:0]   byte_data = 8'h00;
    logic         evt_ready = 1'b1;
    logic [511:0] key_down;
    logic         evt_valid;
    logic [10:0]  evt_data;
    logic [2:0]   fifo_count;
    logic         overflow;

    keyboard_event_queue #(
        .FIFO_DEPTH   (DEPTH),
        .REPEAT_EN    (1),
        .REPEAT_DELAY (DLY),
        .REPEAT_RATE  (RATE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .key_down   (key_down),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_data   (evt_data),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [10:0] evt;
        int          cyc;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [7:0]  b;
        bit          push;
        logic [10:0] evt;
        logic [8:0]  idx;
        logic        val;
    } vec_t;
    vec_t tbl [20];

    logic [7:0] keys [6];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_evt(input logic [10:0] e, input int c);
        sb_t s;
        s.evt = e;
        s.cyc = c;
        sbq.push_back(s);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_key_down"},   key_down, 512'd0);
        check({tag, "_evt_valid"},  evt_valid, 1'b0);
        check({tag, "_evt_data"},   evt_data, 11'd0);
        check({tag, "_fifo_count"}, fifo_count, 3'd0);
        check({tag, "_overflow"},   overflow, 1'b0);
    endtask

    // Scoreboard side: every accepted pop must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_event: got %0h expected none at cycle %0d", evt_data, cyc);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                check("event_data", evt_data, e.evt);
                if (e.cyc >= 0) check("event_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        tbl[0]  = '{8'h1C, 1'b1, 11'h01C, 9'h01C, 1'b1};
        tbl[1]  = '{8'hF0, 1'b0, 11'h000, 9'h01C, 1'b1};
        tbl[2]  = '{8'h1C, 1'b1, 11'h21C, 9'h01C, 1'b0};
        tbl[3]  = '{8'hE0, 1'b0, 11'h000, 9'h175, 1'b0};
        tbl[4]  = '{8'h75, 1'b1, 11'h175, 9'h175, 1'b1};
        tbl[5]  = '{8'hE0, 1'b0, 11'h000, 9'h075, 1'b0};
        tbl[6]  = '{8'hF0, 1'b0, 11'h000, 9'h175, 1'b1};
        tbl[7]  = '{8'h75, 1'b1, 11'h375, 9'h175, 1'b0};
        tbl[8]  = '{8'h1C, 1'b1, 11'h01C, 9'h01C, 1'b1};
        tbl[9]  = '{8'h1C, 1'b0, 11'h000, 9'h01C, 1'b1};
        tbl[10] = '{8'hF0, 1'b0, 11'h000, 9'h01C, 1'b1};
        tbl[11] = '{8'h1C, 1'b1, 11'h21C, 9'h01C, 1'b0};
        tbl[12] = '{8'hFA, 1'b0, 11'h000, 9'h0FA, 1'b0};
        tbl[13] = '{8'h12, 1'b1, 11'h012, 9'h012, 1'b1};
        tbl[14] = '{8'hAA, 1'b0, 11'h000, 9'h012, 1'b0};
        tbl[15] = '{8'hF0, 1'b0, 11'h000, 9'h033, 1'b0};
        tbl[16] = '{8'h33, 1'b0, 11'h000, 9'h033, 1'b0};
        tbl[17] = '{8'h33, 1'b1, 11'h033, 9'h033, 1'b1};
        tbl[18] = '{8'hF0, 1'b0, 11'h000, 9'h033, 1'b1};
        tbl[19] = '{8'h33, 1'b1, 11'h233, 9'h033, 1'b0};
        keys = '{8'h15, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            send_byte(tbl[i].b);
            if (tbl[i].push) expect_evt(tbl[i].evt, cyc);
            check($sformatf("tbl%0d_key", i), key_down[tbl[i].idx], tbl[i].val);
        end
        repeat (30) @(posedge clk);
        #1;
        check("table_drain", sbq.size(), 0);

        // Auto-repeat: make 1D, three repeats at +20/+28/+36, then break stops it.
        send_byte(8'h1D);
        p = cyc;
        expect_evt(11'h01D, p);
        expect_evt(11'h41D, p + DLY);
        expect_evt(11'h41D, p + DLY + RATE);
        expect_evt(11'h41D, p + DLY + 2*RATE);
        check("rep_key_held", key_down[9'h01D], 1'b1);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < p + DLY + 2*RATE);
        send_byte(8'hF0);
        send_byte(8'h1D);
        expect_evt(11'h21D, cyc);
        check("rep_key_released", key_down[9'h01D], 1'b0);
        repeat (30) @(posedge clk);
        #1;
        check("repeat_drain", sbq.size(), 0);

        // Overflow: six makes into a four-deep FIFO with the consumer stalled.
        evt_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send_byte(keys[i]);
            if (i < 4) expect_evt({3'b000, keys[i]}, -1);
        end
        check("ovf_count",    fifo_count, 3'd4);
        check("ovf_flag",     overflow, 1'b1);
        check("ovf_valid",    evt_valid, 1'b1);
        check("ovf_head",     evt_data, 11'h015);
        check("ovf_bitmap",   key_down[9'h02E], 1'b1);
        evt_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        evt_ready = 1'b0;
        check("ovf_count_drained", fifo_count, 3'd0);
        check("ovf_valid_drained", evt_valid, 1'b0);
        check("ovf_flag_sticky",   overflow, 1'b1);
        check("ovf_sb_drained",    sbq.size(), 0);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst2");
        rst = 1'b0;
        evt_ready = 1'b1;

        // Reset after E0 F0 must discard the pending extended break.
        send_byte(8'hE0);
        send_byte(8'hF0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_byte(8'h75);
        expect_evt(11'h075, cyc);
        check("post_rst_make", key_down[9'h075], 1'b1);
        check("post_rst_ext",  key_down[9'h175], 1'b0);
        send_byte(8'hF0);
        send_byte(8'h75);
        expect_evt(11'h275, cyc);

        for (int k = 0; k < 50 && sbq.size() != 0; k++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        check("final_drain", sbq.size(), 0);
        check("final_count", fifo_count, 3'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
